wishbone_burst_master: RTL
==========================

# wishbone_burst_master

Parametrised successor to the single-word host-side Wishbone master. Sits between the host command/stream handlers and the Wishbone interconnect. Executes ping, single and burst reads and writes with configurable data/address width, optional fixed-address (FIFO) mode, bus-error and timeout termination, and valid/ready flow control on both data streams.

## Interface

Parameters:
- DATA_WIDTH, 32: Wishbone data width; multiple of 8.
- ADDR_WIDTH, 32: Wishbone address width.
- COUNT_WIDTH, 16: width of the burst length field.
- TIMEOUT, 255: maximum cycles stb may stay high without ack/err. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  0=ping, 1=write, 2=read, 3=reserved
- cmd_addr  in  ADDR_WIDTH  start address
- cmd_count  in  COUNT_WIDTH  number of words
- cmd_fixed  in  1  1=do not increment address between beats
- wr_valid / wr_ready  in / out  1  write-data handshake
- wr_data  in  DATA_WIDTH  write word
- rd_valid / rd_ready  out / in  1  read-data handshake
- rd_data  out  DATA_WIDTH  read word
- done  out  1  one-cycle pulse at command end
- status  out  2  0=OK, 1=BUS_ERR, 2=TIMEOUT, 3=PING; valid with done, held until the next done
- done_count  out  COUNT_WIDTH  words completed; valid with done
- wb_adr_o, wb_dat_o  out  ADDR_WIDTH, DATA_WIDTH  bus address and write data
- wb_dat_i  in  DATA_WIDTH  bus read data
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  bus controls
- wb_sel_o  out  DATA_WIDTH/8  byte selects; all ones whenever stb is high, else 0
- wb_ack_i, wb_err_i  in  1  slave termination

## Operation

- States: IDLE, WR_DATA, WR_BUS, RD_BUS, RD_OUT, FINISH.
- cmd_ready = (state==IDLE) && !rst, combinational. wr_ready = (state==WR_DATA). rd_valid is high only in RD_OUT.
- On command accept, latch addr, count, fixed and op. Clear the done counter.
  - ping -> FINISH with status PING.
  - count==0 -> FINISH with status OK and done_count 0; no bus cycle.
  - write -> WR_DATA.
  - read -> RD_BUS.
  - op 3 -> FINISH with status BUS_ERR.
- WR_DATA: on a wr_valid&wr_ready handshake, register wr_data into wb_dat_o, raise cyc/stb/we and go to WR_BUS.
- RD_BUS: stb/cyc high, we low.
- ack in WR_BUS/RD_BUS:
  - Drop stb the same edge and increment done_count.
  - Address += 1 unless fixed; wraps modulo 2^ADDR_WIDTH.
  - Read: capture wb_dat_i into rd_data and go to RD_OUT.
  - Write: go to FINISH if this was the last word, else WR_DATA.
- RD_OUT: on the rd_ready handshake, go to FINISH if this was the last word, else RD_BUS.
- cyc stays high for the whole burst, including WR_DATA/RD_OUT gaps. It drops on entry to FINISH.
- err (ack ignored if both are asserted) -> drop cyc/stb, FINISH with BUS_ERR. The errored beat is not counted.
- Timeout counter: clears on every stb rising edge and counts each cycle stb is high. Reaching TIMEOUT with no ack/err -> drop cyc/stb, FINISH with TIMEOUT.
- FINISH: pulse done for one cycle with status and done_count, then return to IDLE.
- Reset outputs: all wb_* 0, rd_valid 0, rd_data 0, done 0, status 0, done_count 0, state IDLE.
- Reset mid-burst drops cyc/stb on the next edge with no done pulse.

## Timing

- Command accept edge -> stb high: 1 cycle for read. For write, 1 cycle after the first wr handshake.
- Zero-wait slave (ack in the first stb cycle):
  - Write beat costs 2 cycles (WR_DATA + WR_BUS) when wr_valid is held high.
  - Read beat costs 2 cycles (RD_BUS + RD_OUT) when rd_ready is held high.
- Last ack -> done pulse: 1 cycle for write. For read, 1 cycle after the final rd handshake.
- Ping/zero-count: done pulses 1 cycle after accept. cmd_ready returns the cycle after done.
- Acks arriving outside WR_BUS/RD_BUS are ignored.

## Test plan

- Ping: accept cmd_op=0 -> done one cycle later, status=3, done_count=0, no stb activity.
- Write burst, addr=0x100, count=4, incrementing, zero-wait ack, wr_valid held -> four stb pulses at 0x100..0x103 with matching data and we=1. cyc high throughout. done with status 0, done_count=4.
- Read burst, count=3, fixed=1, rd_ready toggled 1/0 -> all three beats at the same address. Data returned in order. No beat issued while RD_OUT is stalled. done_count=3.
- Bus error on the 2nd of 4 read beats -> cyc/stb low the next cycle, status=1, done_count=1, rd_valid never raised for the errored beat.
- TIMEOUT=8, slave never acks -> stb high exactly 8 cycles, then cyc/stb low, status=2, done_count=0.
- Address wrap at 0xFFFFFFFF with count=2, plus rst asserted mid-burst in a separate run:
  - Wrap run: second beat at 0x0.
  - Reset run: all outputs zero next cycle, no done pulse, cmd_ready high after rst deasserts.

Source files
------------

// File: rtl/wishbone_burst_master.sv
// Host-side Wishbone master: ping, single and burst reads/writes with stream
// handshakes on both data paths, fixed-address mode, bus-error and timeout termination.
module wishbone_burst_master #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [COUNT_WIDTH-1:0]    cmd_count,
  input  logic                      cmd_fixed,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      done,
  output logic [1:0]                status,
  output logic [COUNT_WIDTH-1:0]    done_count,
  output logic [ADDR_WIDTH-1:0]     wb_adr_o,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]    TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [SEL_W-1:0] SEL_ALL  = {SEL_W{1'b1}};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_DATA = 3'd1;
  localparam logic [2:0] S_WR_BUS  = 3'd2;
  localparam logic [2:0] S_RD_BUS  = 3'd3;
  localparam logic [2:0] S_RD_OUT  = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  localparam logic [1:0] OP_PING  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BUS_ERR = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_PING    = 2'd3;

  logic [2:0]             state_q,   state_d;
  logic [ADDR_WIDTH-1:0]  adr_q,     adr_d;
  logic [COUNT_WIDTH-1:0] count_q,   count_d;
  logic                   fixed_q,   fixed_d;
  logic [COUNT_WIDTH-1:0] cnt_q,     cnt_d;
  logic [1:0]             status_q,  status_d;
  logic                   done_q,    done_d;
  logic                   cyc_q,     cyc_d;
  logic                   stb_q,     stb_d;
  logic                   we_q,      we_d;
  logic [SEL_W-1:0]       sel_q,     sel_d;
  logic [DATA_WIDTH-1:0]  dat_q,     dat_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [TW-1:0]          tmo_q,     tmo_d;

  logic [COUNT_WIDTH-1:0] cnt_inc_s;
  logic                   tmo_hit_s;

  assign cnt_inc_s = cnt_q + COUNT_WIDTH'(1);
  assign tmo_hit_s = (TIMEOUT != 0) && (tmo_q == TMO_LAST);

  assign cmd_ready  = (state_q == S_IDLE) && !rst;
  assign wr_ready   = (state_q == S_WR_DATA);
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign done       = done_q;
  assign status     = status_q;
  assign done_count = cnt_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_we_o    = we_q;
  assign wb_sel_o   = sel_q;

  // Next-state and next-output computation for the burst sequencer.
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    count_d   = count_q;
    fixed_d   = fixed_q;
    cnt_d     = cnt_q;
    status_d  = status_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    rd_data_d = rd_data_q;
    tmo_d     = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          adr_d   = cmd_addr;
          count_d = cmd_count;
          fixed_d = cmd_fixed;
          cnt_d   = '0;
          if (cmd_op == OP_PING) begin
            state_d  = S_FINISH;
            status_d = ST_PING;
          end else if (cmd_count == '0) begin
            state_d  = S_FINISH;
            status_d = ST_OK;
          end else if (cmd_op == OP_WRITE) begin
            state_d = S_WR_DATA;
          end else if (cmd_op == OP_READ) begin
            state_d = S_RD_BUS;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b0;
            sel_d   = SEL_ALL;
            tmo_d   = '0;
          end else begin
            state_d  = S_FINISH;
            status_d = ST_BUS_ERR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WR_DATA: begin
        if (wr_valid) begin
          dat_d   = wr_data;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          sel_d   = SEL_ALL;
          tmo_d   = '0;
          state_d = S_WR_BUS;
        end else begin
          state_d = S_WR_DATA;
        end
      end

      // err wins over a simultaneous ack; the errored beat is not counted
      S_WR_BUS, S_RD_BUS: begin
        if (wb_err_i) begin
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          we_d     = 1'b0;
          sel_d    = '0;
          status_d = ST_BUS_ERR;
          state_d  = S_FINISH;
        end else if (wb_ack_i) begin
          stb_d = 1'b0;
          sel_d = '0;
          cnt_d = cnt_inc_s;
          adr_d = fixed_q ? adr_q : adr_q + ADDR_WIDTH'(1);
          if (state_q == S_RD_BUS) begin
            rd_data_d = wb_dat_i;
            state_d   = S_RD_OUT;
          end else if (cnt_inc_s == count_q) begin
            cyc_d    = 1'b0;
            we_d     = 1'b0;
            status_d = ST_OK;
            state_d  = S_FINISH;
          end else begin
            state_d = S_WR_DATA;
          end
        end else if (tmo_hit_s) begin
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          we_d     = 1'b0;
          sel_d    = '0;
          status_d = ST_TIMEOUT;
          state_d  = S_FINISH;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_RD_OUT: begin
        if (rd_ready) begin
          if (cnt_q == count_q) begin
            cyc_d    = 1'b0;
            status_d = ST_OK;
            state_d  = S_FINISH;
          end else begin
            stb_d   = 1'b1;
            sel_d   = SEL_ALL;
            tmo_d   = '0;
            state_d = S_RD_BUS;
          end
        end else begin
          state_d = S_RD_OUT;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
        sel_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    done_d     = (state_d == S_FINISH);
    rd_valid_d = (state_d == S_RD_OUT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      adr_q      <= '0;
      count_q    <= '0;
      fixed_q    <= 1'b0;
      cnt_q      <= '0;
      status_q   <= ST_OK;
      done_q     <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      dat_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      count_q    <= count_d;
      fixed_q    <= fixed_d;
      cnt_q      <= cnt_d;
      status_q   <= status_d;
      done_q     <= done_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      dat_q      <= dat_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule
